// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared line levels, state encoding and helpers for the serial link
package serial_link_pkg;

  // Line levels seen on the serial wire
  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

  localparam int DEFAULT_DATA_W = 4;

  // Counter widths sized for the widest supported payload (16) and gap
  localparam int CNT_W = 5;
  localparam int GAP_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } link_state_e;

  // Even parity over a zero-extended payload word
  function automatic logic even_parity(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_tx_shift.sv
// rtl/serial_tx_shift.sv - loadable payload shift register with selectable bit order
module serial_tx_shift #(
  parameter int DATA_W    = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  output logic              sout
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;

  // Load wins over shift; the outgoing bit always sits at the end selected by MSB_FIRST
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        shreg_d = shreg_q << 1;
      end else begin
        shreg_d = shreg_q >> 1;
      end
    end
  end

  // Shift register storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];

endmodule

// File: rtl/serial_tx4.sv
// rtl/serial_tx4.sv - framed parallel-to-serial transmitter (optional parity via SERIAL_TX_PARITY_EN)
module serial_tx4
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              a,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             a_q, a_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;
  logic             load;
  logic             shift_en;
  logic             shift_out;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // Ready in IDLE and also in the final gap cycle, so a held din_valid
  // starts the next frame's start bit right after the gap with no idle cycle
  assign din_ready = !rst && ((state_q == IDLE) ||
                              ((state_q == STOP) && (gap_q == LAST_GAP)));
  assign accept    = din_valid && din_ready;
  assign load      = accept;

  serial_tx_shift #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .shift (shift_en),
    .sout  (shift_out)
  );

  // Next-state, counters and the registered line level for the upcoming cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;
    a_d          = LINE_IDLE;
    shift_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
          gap_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        state_d = STOP;
        gap_d   = '0;
      end
`endif
      STOP: begin
        if (gap_q == LAST_GAP) begin
          frame_done_d = 1'b1;
          state_d      = accept ? START : IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is registered, so it follows the state being entered;
    // a data bit is consumed from the shifter in the cycle it is registered
    case (state_d)
      START:  a_d = LINE_START;
      DATA: begin
        a_d      = shift_out;
        shift_en = 1'b1;
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: a_d = parity_q;
`endif
      STOP:   a_d = LINE_STOP;
      default: a_d = LINE_IDLE;
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from the word at capture time
  always_comb begin
    parity_d = parity_q;
    if (load) parity_d = even_parity(16'(din));
  end
`endif

  // State and output registers; reset aborts any frame without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      a_q          <= LINE_IDLE;
      frame_done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      a_q          <= a_d;
      frame_done_q <= frame_done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign a          = a_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_tx4.sv
// tb/tb_serial_tx4.sv - directed table-driven bench for serial_tx4
module tb_serial_tx4;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       a;
  logic       busy;
  logic       frame_done;
  logic       lsb_ready;
  logic       lsb_a;
  logic       lsb_busy;
  logic       lsb_done;

  int total = 0;
  int bad   = 0;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [3:0] din;
    logic       exp_ready;
    logic       exp_a;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  serial_tx4 #(.DATA_W(4), .MSB_FIRST(1), .GAP_CYCLES(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .a          (a),
    .busy       (busy),
    .frame_done (frame_done)
  );

  serial_tx4 #(.DATA_W(4), .MSB_FIRST(0), .GAP_CYCLES(1)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (lsb_ready),
    .a          (lsb_a),
    .busy       (lsb_busy),
    .frame_done (lsb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [3:0] d,
                     input logic rdy, input logic ea, input logic eb, input logic ed);
    vec_t t;
    t.rst = r; t.valid = v; t.din = d;
    t.exp_ready = rdy; t.exp_a = ea; t.exp_busy = eb; t.exp_done = ed;
    vecs.push_back(t);
  endtask

  logic lsb_exp[FRAME_LEN];

  initial begin
    rst = 1'b1;
    din_valid = 1'b0;
    din = 4'b0000;

    // Reset held 3 cycles with a word offered: nothing accepted
    add(1, 1, 4'b1011, 0, 0, 0, 0);
    add(1, 1, 4'b1011, 0, 0, 0, 0);
    add(1, 1, 4'b1011, 0, 0, 0, 0);
    // Single frame 1011, MSB first
    add(0, 1, 4'b1011, 1, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 1, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(0, 0, 4'b0000, 0, 1, 1, 0);
`endif
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0, 0);
    // Back-to-back 0110 then 1001, 1111 offered mid-frame must be ignored
    add(0, 1, 4'b0110, 1, 1, 1, 0);
    add(0, 1, 4'b1001, 0, 0, 1, 0);
    add(0, 1, 4'b1111, 0, 1, 1, 0);
    add(0, 1, 4'b1111, 0, 1, 1, 0);
    add(0, 1, 4'b1111, 0, 0, 1, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(0, 1, 4'b1111, 0, 0, 1, 0);
`endif
    add(0, 1, 4'b1001, 0, 0, 1, 0);
    add(0, 1, 4'b1001, 1, 1, 1, 1);
    add(0, 0, 4'b1111, 0, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 1, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(0, 0, 4'b0000, 0, 0, 1, 0);
`endif
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0, 0);
    // Reset during data bit 2 of a 1011 frame: abort, no done pulse
    add(0, 1, 4'b1011, 1, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 0, 1, 0);
    add(1, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      din_valid = vecs[i].valid;
      din       = vecs[i].din;
      #1;
      check($sformatf("row%0d din_ready", i), din_ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("row%0d a", i), a, vecs[i].exp_a);
      check($sformatf("row%0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("row%0d frame_done", i), frame_done, vecs[i].exp_done);
    end

    // LSB-first instance, din=1011: start, 1,1,0,1, (parity 1), stop
    lsb_exp[0] = 1'b1;
    lsb_exp[1] = 1'b1;
    lsb_exp[2] = 1'b1;
    lsb_exp[3] = 1'b0;
    lsb_exp[4] = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    lsb_exp[5] = 1'b1;
    lsb_exp[6] = 1'b0;
`else
    lsb_exp[5] = 1'b0;
`endif
    rst       = 1'b0;
    din       = 4'b1011;
    din_valid = 1'b1;
    #1;
    check("lsb din_ready", lsb_ready, 1'b1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = 4'b0000;
      check($sformatf("lsb a bit%0d", i), lsb_a, lsb_exp[i]);
      check($sformatf("lsb busy bit%0d", i), lsb_busy, 1'b1);
      check($sformatf("lsb done bit%0d", i), lsb_done, 1'b0);
    end
    @(posedge clk);
    #1;
    check("lsb frame_done end", lsb_done, 1'b1);
    check("lsb busy end", lsb_busy, 1'b0);
    check("lsb a end", lsb_a, 1'b0);
    @(posedge clk);
    #1;
    check("lsb frame_done clear", lsb_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
